// File: rtl/and_toggle_driver.sv
// and_toggle_driver
// Stimulus-and-response engine for a toggle-encoded two-input AND cell.
// Accepts one operand pair at a time, issues a/b toggles GAP cycles apart,
// toggles the cell clock GAP cycles later, samples the cell output SETTLE
// cycles after that and reports whether the output toggled.
// Optional feature macro: AND_DRV_CHECK_EN enables the sticky err flag
// (result comparator plus spurious-toggle monitor); without it err is 0.
module and_toggle_driver #(
   parameter int GAP    = 8,
   parameter int SETTLE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_a,
   input  logic in_b,
   output logic a_out,
   output logic b_out,
   output logic clk_out,
   input  logic out_in,
   output logic res_valid,
   output logic res_data,
   output logic err
);

   localparam logic [7:0] GAP_M1    = 8'(GAP - 1);
   localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SLOT_B = 3'd1,
      ST_SLOT_C = 3'd2,
      ST_SETTLE = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   state_t     state_r, state_s;
   logic [7:0] cnt_r, cnt_s;
   logic       b_lat_r, b_lat_s;
   logic       out_prev_r, out_prev_s;
   logic       a_out_r, a_out_s;
   logic       b_out_r, b_out_s;
   logic       clk_out_r, clk_out_s;
   logic       ready_r, ready_s;
   logic       res_valid_r, res_valid_s;
   logic       res_data_r, res_data_s;

`ifdef AND_DRV_CHECK_EN
   logic       a_lat_r, a_lat_s;
   logic       err_r, err_s;
`endif

   // Next-state, counter and toggle-line decisions for the slot sequencer.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      b_lat_s     = b_lat_r;
      out_prev_s  = out_prev_r;
      a_out_s     = a_out_r;
      b_out_s     = b_out_r;
      clk_out_s   = clk_out_r;
      res_valid_s = 1'b0;
      res_data_s  = res_data_r;
`ifdef AND_DRV_CHECK_EN
      a_lat_s     = a_lat_r;
      err_s       = err_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (in_valid && ready_r) begin
`ifdef AND_DRV_CHECK_EN
               a_lat_s = in_a;
`endif
               b_lat_s = in_b;
               a_out_s = a_out_r ^ in_a;
               cnt_s   = GAP_M1;
               state_s = ST_SLOT_B;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SLOT_B: begin
`ifdef AND_DRV_CHECK_EN
            // Cell output must not move before its clock toggle.
            if (out_in != out_prev_r) begin
               err_s = 1'b1;
            end else begin
               err_s = err_r;
            end
`endif
            if (cnt_r == 8'd0) begin
               b_out_s = b_out_r ^ b_lat_r;
               cnt_s   = GAP_M1;
               state_s = ST_SLOT_C;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_SLOT_C: begin
`ifdef AND_DRV_CHECK_EN
            if (out_in != out_prev_r) begin
               err_s = 1'b1;
            end else begin
               err_s = err_r;
            end
`endif
            if (cnt_r == 8'd0) begin
               clk_out_s = ~clk_out_r;
               cnt_s     = SETTLE_M1;
               state_s   = ST_SETTLE;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == 8'd0) begin
               res_data_s  = out_in ^ out_prev_r;
               out_prev_s  = out_in;
               res_valid_s = 1'b1;
               state_s     = ST_REPORT;
`ifdef AND_DRV_CHECK_EN
               // Flag lands together with the result strobe.
               if ((out_in ^ out_prev_r) != (a_lat_r & b_lat_r)) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_r;
               end
`endif
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_REPORT: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
         end
      endcase
      ready_s = (state_s == ST_IDLE);
   end

   // State register; async reset drops every line to 0 at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 8'd0;
         b_lat_r     <= 1'b0;
         out_prev_r  <= 1'b0;
         a_out_r     <= 1'b0;
         b_out_r     <= 1'b0;
         clk_out_r   <= 1'b0;
         ready_r     <= 1'b0;
         res_valid_r <= 1'b0;
         res_data_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         b_lat_r     <= b_lat_s;
         out_prev_r  <= out_prev_s;
         a_out_r     <= a_out_s;
         b_out_r     <= b_out_s;
         clk_out_r   <= clk_out_s;
         ready_r     <= ready_s;
         res_valid_r <= res_valid_s;
         res_data_r  <= res_data_s;
      end
   end

`ifdef AND_DRV_CHECK_EN
   // Check-feature registers: operand a latch and the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_lat_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         a_lat_r <= a_lat_s;
         err_r   <= err_s;
      end
   end
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = ready_r;
   assign a_out     = a_out_r;
   assign b_out     = b_out_r;
   assign clk_out   = clk_out_r;
   assign res_valid = res_valid_r;
   assign res_data  = res_data_r;

endmodule

// File: tb/tb_and_toggle_driver.sv
// Self-checking bench for and_toggle_driver: behavioural AND-cell model,
// event-time logging of every line, and a transaction-level expectation
// (line levels, event times, result value/time) per operand pair.
module tb_and_toggle_driver;

   localparam int GAP    = 8;
   localparam int SETTLE = 4;
   localparam int RES_LAT = 2 * GAP + SETTLE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_a = 1'b0;
   logic in_b = 1'b0;
   logic out_in = 1'b0;
   logic in_ready, a_out, b_out, clk_out, res_valid, res_data, err;

   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   // Cell model / monitor state (owned by the monitor process).
   logic pa = 1'b0, pb = 1'b0;
   logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
   int   due = -1;
   int   t_a = -1, t_b = -1, t_c = -1;
   int   n_res = 0;
   logic res_q[$];
   logic spur_done = 1'b0;

   // Controls owned by the stimulus block.
   logic force_nt = 1'b0;
   logic spur_req = 1'b0;
   logic exp_a = 1'b0, exp_b = 1'b0, exp_c = 1'b0, exp_err = 1'b0;

   and_toggle_driver #(.GAP(GAP), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .a_out(a_out), .b_out(b_out),
      .clk_out(clk_out), .out_in(out_in), .res_valid(res_valid),
      .res_data(res_data), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor plus toggle-AND cell: out toggles 2 cycles after a clk event
   // if both a and b saw an event since the previous clk event.
   always @(negedge clk) begin
      if (rst) begin
         out_in = 1'b0; pa = 1'b0; pb = 1'b0; due = -1; spur_done = 1'b0;
      end else begin
         if (a_out !== prev_a) begin t_a = cyc; pa = 1'b1; end
         if (b_out !== prev_b) begin t_b = cyc; pb = 1'b1; end
         if (clk_out !== prev_c) begin
            t_c = cyc;
            if (pa && pb && !force_nt) due = cyc + 2;
            pa = 1'b0; pb = 1'b0;
         end
         if (cyc == due) out_in = ~out_in;
         if (spur_req && !spur_done) begin out_in = ~out_in; spur_done = 1'b1; end
         if (res_valid === 1'b1) begin n_res++; res_q.push_back(res_data); end
      end
      prev_a = a_out; prev_b = b_out; prev_c = clk_out;
   end

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin step(); n++; end
      chk("ready_wait", int'(n < 100), 1);
   endtask

   // One complete transaction with full timing/level/result checks.
   task automatic do_op(input logic a, input logic b);
      int e, n;
      logic er;
      wait_ready();
      in_valid = 1'b1; in_a = a; in_b = b;
      step();
      e = cyc;
      in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
      exp_a ^= a; exp_b ^= b; exp_c ^= 1'b1;
      chk("ready_low_after_accept", int'(in_ready), 0);
      n = 0;
      while (res_valid !== 1'b1 && n < 60) begin step(); n++; end
      chk("res_time", cyc - e, RES_LAT);
      er = a & b & ~force_nt;
`ifdef AND_DRV_CHECK_EN
      if (er != (a & b)) exp_err = 1'b1;
`endif
      chk("res_data", int'(res_data), int'(er));
      if (a) chk("a_time", t_a - e, 0);
      if (b) chk("b_time", t_b - e, GAP);
      chk("clk_time", t_c - e, 2 * GAP);
      chk("a_level", int'(a_out), int'(exp_a));
      chk("b_level", int'(b_out), int'(exp_b));
      chk("clk_level", int'(clk_out), int'(exp_c));
      chk("err", int'(err), int'(exp_err));
      chk("ready_in_report", int'(in_ready), 0);
      step();
      chk("res_valid_one_cycle", int'(res_valid), 0);
      chk("ready_after_report", int'(in_ready), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_a", int'(a_out), 0);
      chk("rst_b", int'(b_out), 0);
      chk("rst_clk", int'(clk_out), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ready", int'(in_ready), 0);
      exp_a = 1'b0; exp_b = 1'b0; exp_c = 1'b0; exp_err = 1'b0;
      step(); step();
      rst = 1'b0;
      step(); step();
      chk("ready_after_rst", int'(in_ready), 1);
   endtask

   initial begin
      int e, n, r0, ra, rb;
      logic [1:0] pairs [4];
      logic exp_q[$];

      step();
      chk("rst_res_data", int'(res_data), 0);
      do_reset();

      // Directed (1,1) with toggling cell.
      do_op(1'b1, 1'b1);

      // Sequence from reset: (1,0), (0,1), (0,0) -> lines end at 1,1,1.
      do_reset();
      do_op(1'b1, 1'b0);
      do_op(1'b0, 1'b1);
      do_op(1'b0, 1'b0);
      chk("seq_end_lines", int'({a_out, b_out, clk_out}), 7);

      // Randomized pairs.
      for (int i = 0; i < 8; i++) begin
         ra = int'($urandom_range(0, 1));
         rb = int'($urandom_range(0, 1));
         do_op(ra[0], rb[0]);
      end

      // in_valid held high across 4 pairs.
      for (int i = 0; i < 4; i++) pairs[i] = 2'($urandom_range(0, 3));
      pairs[0] = 2'b11;
      wait_ready();
      r0 = n_res;
      res_q.delete();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_a = pairs[i][1]; in_b = pairs[i][0];
         exp_q.push_back(pairs[i][1] & pairs[i][0]);
         n = 0;
         while (in_ready !== 1'b1 && n < 60) begin step(); n++; end
         step();
         if (i == 3) in_valid = 1'b0;
         n = 0;
         while (in_ready !== 1'b1 && n < 60) begin step(); n++; end
         chk("stream_ready_low", n, RES_LAT + 1);
      end
      in_valid = 1'b0;
      step(); step();
      chk("stream_pulses", n_res - r0, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < res_q.size()) chk("stream_data", int'(res_q[i]), int'(exp_q[i]));
      end

      // Reset during an operation at E+10.
      wait_ready();
      in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
      step();
      e = cyc;
      in_valid = 1'b0;
      while (cyc < e + 10) step();
      r0 = n_res;
      do_reset();
      for (int i = 0; i < 30; i++) step();
      chk("abort_no_result", n_res - r0, 0);
      do_op(1'b1, 1'b1);

`ifdef AND_DRV_CHECK_EN
      // Cell forced silent: mismatch sets sticky err in REPORT.
      force_nt = 1'b1;
      do_op(1'b1, 1'b1);
      force_nt = 1'b0;
      step();
      chk("err_sticky", int'(err), 1);

      // Spurious output toggle during SLOT_B.
      do_reset();
      wait_ready();
      in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
      step();
      e = cyc;
      in_valid = 1'b0;
      while (cyc < e + 3) step();
      spur_req = 1'b1;
      while (cyc < e + 6) step();
      chk("spur_err", int'(err), 1);
      chk("spur_before_clk", int'(clk_out), 0);
      spur_req = 1'b0;
      for (int i = 0; i < 30; i++) step();
      chk("spur_err_sticky", int'(err), 1);
      do_reset();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
